// File: rtl/dac_update_sequencer.sv
// Feeds per-channel actuator updates from a small FIFO to the serial DAC transmitter.
// A shared LDAC strobe is pulsed after the last word of each frame.
module dac_update_sequencer #(
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned BUSY_TIMEOUT = 64,
    parameter int unsigned LDAC_CYCLES  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_ch,
    input  logic [11:0] in_data,
    input  logic        in_last,
    output logic        dac_start,
    output logic [15:0] dac_data,
    input  logic        dac_busy,
    output logic        ldac_n,
    output logic        seq_busy,
    output logic        err_timeout,
    output logic [15:0] frame_cnt
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned TW = $clog2(BUSY_TIMEOUT + 1);
    localparam int unsigned LW = $clog2(LDAC_CYCLES + 1);
    localparam logic [AW:0]   FULL_CNT  = FIFO_DEPTH[AW:0];
    localparam logic [TW-1:0] TMO_LAST  = TW'(BUSY_TIMEOUT - 1);
    localparam logic [LW-1:0] LDAC_LAST = LW'(LDAC_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, LDAC} state_t;
    state_t state;

    logic [15:0]   mem [FIFO_DEPTH];
    logic [15:0]   head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          last_q;
    logic [TW-1:0] tmo_cnt;
    logic [LW-1:0] ldac_cnt;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign in_ready = !full;
    assign push     = in_valid && !full;
    // Never pop (and so never start) while the transmitter still reports busy.
    assign pop      = (state == IDLE) && !empty && !dac_busy;
    assign head     = mem[rd_ptr];
    assign seq_busy = (state != IDLE) || !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {in_last, in_ch, in_data};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            dac_start   <= 1'b0;
            dac_data    <= '0;
            last_q      <= 1'b0;
            tmo_cnt     <= '0;
            ldac_cnt    <= '0;
            ldac_n      <= 1'b1;
            err_timeout <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            dac_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        dac_data  <= {1'b0, head[14:0]};
                        last_q    <= head[15];
                        dac_start <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    tmo_cnt <= '0;
                    state   <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (dac_busy) begin
                        state <= WAIT_DONE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        // Word is dropped, but a last word still closes the frame.
                        err_timeout <= 1'b1;
                        if (last_q) begin
                            ldac_n   <= 1'b0;
                            ldac_cnt <= '0;
                            state    <= LDAC;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                WAIT_DONE: begin
                    if (!dac_busy) begin
                        if (last_q) begin
                            ldac_n   <= 1'b0;
                            ldac_cnt <= '0;
                            state    <= LDAC;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                LDAC: begin
                    if (ldac_cnt == LDAC_LAST) begin
                        ldac_n    <= 1'b1;
                        frame_cnt <= frame_cnt + 16'd1;
                        state     <= IDLE;
                    end else begin
                        ldac_cnt <= ldac_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
